dm_access_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the byte-addressed, big-endian data memory (DM).

---
 rtl/dm_access_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_access_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_arbiter.sv
// Round-robin sequencer sharing the big-endian data memory between two requesters.
// One word access in flight at a time: IDLE -> ACCESS -> WAIT x RD_LATENCY -> DONE.
module dm_access_arbiter #(
    parameter int MEM_BYTES  = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_data,
    output logic        dm_MemRead,
    output logic        dm_MemWrite,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [2:0]  CNT_LAST  = 3'(RD_LATENCY - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        last_gnt;
    logic        win_p0;
    logic        we_p0;
    logic        err_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [31:0] rdata_p1;

    logic        req_any;
    logic        pick;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        in_access, in_wait, in_done;
    logic        access_ok;
    logic [31:0] rd_word;

    // Arbitration: a tie goes to the requester that was not granted last.
    always_comb begin
        req_any   = r0_req | r1_req;
        pick      = (r0_req && r1_req) ? ~last_gnt : ~r0_req;
        sel_we    = pick ? r1_we    : r0_we;
        sel_addr  = pick ? r1_addr  : r0_addr;
        sel_wdata = pick ? r1_wdata : r0_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (req_any) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_WAIT;
            S_WAIT:   if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            last_gnt <= 1'b1;
            win_p0   <= 1'b0;
            we_p0    <= 1'b0;
            err_p0   <= 1'b0;
            addr_p0  <= 32'd0;
            wdata_p0 <= 32'd0;
            rdata_p1 <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_any) begin
                win_p0   <= pick;
                last_gnt <= pick;
                we_p0    <= sel_we;
                err_p0   <= sel_err;
                // Rejected accesses leave the DM bus values untouched.
                if (!sel_err) begin
                    addr_p0  <= sel_addr;
                    wdata_p0 <= sel_wdata;
                end
            end
            if (state == S_ACCESS)
                cnt <= 3'd0;
            else if (state == S_WAIT)
                cnt <= cnt + 3'd1;
            if (state == S_WAIT && cnt == CNT_LAST && !we_p0 && !err_p0)
                rdata_p1 <= dm_rdata;
        end
    end

    // Outputs decode straight from reset registers so a reset drops them at once.
    always_comb begin
        in_access   = (state == S_ACCESS);
        in_wait     = (state == S_WAIT);
        in_done     = (state == S_DONE);
        access_ok   = !err_p0;
        rd_word     = (in_done && !we_p0 && access_ok) ? rdata_p1 : 32'd0;
        r0_gnt      = in_access && !win_p0;
        r1_gnt      = in_access &&  win_p0;
        r0_rvalid   = in_done && !win_p0;
        r1_rvalid   = in_done &&  win_p0;
        r0_err      = in_done && !win_p0 && err_p0;
        r1_err      = in_done &&  win_p0 && err_p0;
        r0_rdata    = win_p0 ? 32'd0 : rd_word;
        r1_rdata    = win_p0 ? rd_word : 32'd0;
        dm_addr     = addr_p0;
        dm_data     = wdata_p0;
        dm_MemRead  = (in_access || in_wait) && !we_p0 && access_ok;
        dm_MemWrite = in_access && we_p0 && access_ok;
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: RD_LATENCY=1 instance with a byte memory
// model, plus a RD_LATENCY=3 instance for the long-wait timing case.
module tb_dm_access_arbiter;

    localparam int LAT_A = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] dm_addr, dm_data, dm_rdata;
    logic        dm_MemRead, dm_MemWrite;

    logic        b_r0_req, b_r0_we, b_r1_req, b_r1_we;
    logic [31:0] b_r0_addr, b_r0_wdata, b_r1_addr, b_r1_wdata;
    logic        b_r0_gnt, b_r0_rvalid, b_r0_err, b_r1_gnt, b_r1_rvalid, b_r1_err;
    logic [31:0] b_r0_rdata, b_r1_rdata;
    logic [31:0] b_dm_addr, b_dm_data, b_dm_rdata;
    logic        b_dm_MemRead, b_dm_MemWrite;

    dm_access_arbiter #(.MEM_BYTES(128), .RD_LATENCY(LAT_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .dm_addr(dm_addr), .dm_data(dm_data), .dm_MemRead(dm_MemRead),
        .dm_MemWrite(dm_MemWrite), .dm_rdata(dm_rdata)
    );

    dm_access_arbiter #(.MEM_BYTES(128), .RD_LATENCY(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata), .r0_err(b_r0_err),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata), .r1_err(b_r1_err),
        .dm_addr(b_dm_addr), .dm_data(b_dm_data), .dm_MemRead(b_dm_MemRead),
        .dm_MemWrite(b_dm_MemWrite), .dm_rdata(b_dm_rdata)
    );

    // Big-endian byte memory behind instance A.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (dm_MemWrite) begin
            mem[dm_addr[6:0]]              <= dm_data[31:24];
            mem[7'(dm_addr[6:0] + 7'd1)]   <= dm_data[23:16];
            mem[7'(dm_addr[6:0] + 7'd2)]   <= dm_data[15:8];
            mem[7'(dm_addr[6:0] + 7'd3)]   <= dm_data[7:0];
        end
    end
    assign dm_rdata = {mem[dm_addr[6:0]], mem[7'(dm_addr[6:0] + 7'd1)],
                       mem[7'(dm_addr[6:0] + 7'd2)], mem[7'(dm_addr[6:0] + 7'd3)]};

    assign b_dm_rdata = b_dm_MemRead ? (32'hCAFEF00D ^ b_dm_addr) : 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single-requester transaction on instance A, started from an IDLE cycle.
    task automatic xact(input string tag, input int p, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        int nrd = 0;
        int nwr = 0;
        if (p == 0) begin r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1; end
        else        begin r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1; end
        @(posedge clk); #1;
        chk({tag, " gnt"},       (p == 0) ? r0_gnt : r1_gnt, 32'd1);
        chk({tag, " loser gnt"}, (p == 0) ? r1_gnt : r0_gnt, 32'd0);
        if (!exp_err) chk({tag, " dm_addr"}, dm_addr, addr);
        if (we && !exp_err) chk({tag, " dm_data"}, dm_data, wdata);
        r0_req = 1'b0;
        r1_req = 1'b0;
        nrd += int'(dm_MemRead);
        nwr += int'(dm_MemWrite);
        for (int i = 0; i < LAT_A; i++) begin
            @(posedge clk); #1;
            nrd += int'(dm_MemRead);
            nwr += int'(dm_MemWrite);
            chk({tag, " early rvalid"}, {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
        end
        @(posedge clk); #1;
        nrd += int'(dm_MemRead);
        nwr += int'(dm_MemWrite);
        chk({tag, " rvalid"},       (p == 0) ? r0_rvalid : r1_rvalid, 32'd1);
        chk({tag, " loser rvalid"}, (p == 0) ? r1_rvalid : r0_rvalid, 32'd0);
        chk({tag, " err"},          (p == 0) ? r0_err : r1_err, 32'(exp_err));
        chk({tag, " rdata"},        (p == 0) ? r0_rdata : r1_rdata, exp_rd);
        chk({tag, " read strobes"},  32'(nrd), (!we && !exp_err) ? 32'(1 + LAT_A) : 32'd0);
        chk({tag, " write strobes"}, 32'(nwr), (we && !exp_err) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   order[8];
        int   ng;
        logic both_gnt;
        int   nrd_b;

        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h4; r1_wdata = 32'h0;
        b_r0_req = 1'b0; b_r0_we = 1'b0; b_r0_addr = 32'h0; b_r0_wdata = 32'h0;
        b_r1_req = 1'b0; b_r1_we = 1'b0; b_r1_addr = 32'h0; b_r1_wdata = 32'h0;

        #12;
        chk("reset strobes", {30'd0, dm_MemRead, dm_MemWrite}, 32'd0);
        chk("reset gnt/rvalid/err",
            {26'd0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err}, 32'd0);
        chk("reset rdata", r0_rdata | r1_rdata, 32'd0);
        chk("reset dm_addr", dm_addr, 32'd0);
        chk("reset dm_data", dm_data, 32'd0);
        #10 rst_n = 1'b1;

        // T2: both requesters hold req from reset.
        ng = 0;
        both_gnt = 1'b0;
        for (int c = 0; c < 200 && ng < 8; c++) begin
            @(posedge clk); #1;
            if (r0_gnt && r1_gnt) both_gnt = 1'b1;
            else if (r0_gnt) begin order[ng] = 0; ng++; end
            else if (r1_gnt) begin order[ng] = 1; ng++; end
        end
        chk("T2 grant count", 32'(ng), 32'd8);
        chk("T2 double grant", 32'(both_gnt), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("T2 order[%0d]", i), 32'(order[i]), 32'(i % 2));
        r0_req = 1'b0;
        r1_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // T1: write then read back.
        xact("T1 wr", 0, 1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0);
        xact("T1 rd", 0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);

        // T3: rejected accesses.
        xact("T3 misaligned", 1, 1'b0, 32'h7E, 32'h0, 32'h0, 1'b1);
        xact("T3 range",      1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);

        // T4: last word write by r1, readback by r0.
        xact("T4 wr", 1, 1'b1, 32'h7C, 32'hAABBCCDD, 32'h0, 1'b0);
        xact("T4 rd", 0, 1'b0, 32'h7C, 32'h0, 32'hAABBCCDD, 1'b0);

        // T5: reset during WAIT of an r0 read.
        r0_we = 1'b0; r0_addr = 32'h10; r0_req = 1'b1;
        @(posedge clk); #1;
        chk("T5 gnt", 32'(r0_gnt), 32'd1);
        r0_req = 1'b0;
        @(posedge clk); #1;
        chk("T5 wait read strobe", 32'(dm_MemRead), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("T5 async strobe drop", 32'(dm_MemRead), 32'd0);
        chk("T5 async dm_addr", dm_addr, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("T5 no rvalid", 32'(r0_rvalid), 32'd0);
        end
        r0_addr = 32'h0; r0_req = 1'b1;
        r1_addr = 32'h4; r1_we = 1'b0; r1_req = 1'b1;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("T5 tie r0 gnt", 32'(r0_gnt), 32'd1);
        chk("T5 tie r1 gnt", 32'(r1_gnt), 32'd0);
        r0_req = 1'b0;
        r1_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // T6: RD_LATENCY=3 instance.
        nrd_b = 0;
        b_r0_addr = 32'h20; b_r0_we = 1'b0; b_r0_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                chk("T6 gnt", 32'(b_r0_gnt), 32'd1);
                b_r0_req = 1'b0;
            end
            nrd_b += int'(b_dm_MemRead);
            chk($sformatf("T6 rvalid k+%0d", i), 32'(b_r0_rvalid), (i == 5) ? 32'd1 : 32'd0);
            if (i == 5) chk("T6 rdata", b_r0_rdata, 32'hCAFEF02D);
        end
        chk("T6 read strobe cycles", 32'(nrd_b), 32'd4);
        chk("T6 no write strobe", 32'(b_dm_MemWrite), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
